mini_bcd_conv: RTL and testbench

//  Downstream stage of the mini ALU. Converts a binary result (product, quotient
//  or remainder) to packed BCD for the display path, using sequential

---
 rtl/mini_bcd_conv.sv | 147 ++++++++++++++
 tb/tb_mini_bcd_conv.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mini_bcd_conv.sv
// mini_bcd_conv -- sequential binary-to-packed-BCD converter (double-dabble).
// One operand bit is consumed per clock, so a conversion takes IN_W cycles.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        synchronous reset, active-high
//   in_valid   operand on in_bin is valid
//   in_ready   block is idle and can take an operand
//   in_bin     unsigned binary operand [IN_W-1:0]
//   out_valid  bcd/ndig hold a completed result
//   out_ready  consumer takes the result
//   bcd        packed BCD, digit 0 in [3:0]
//   ndig       significant digit count, 1..DIGITS
//   busy       conversion in progress
//   seg        (MINI_BCD_SEG_EN only) 7-segment gfedcba per digit, digit 0
//              in [6:0], digits above ndig blanked
//
// Optional feature macro: MINI_BCD_SEG_EN adds the registered seg output.

// Per-digit correction: a digit >= 5 would carry past 9 after the shift.
module mini_bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module mini_bcd_conv #(
  parameter int IN_W   = 17,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [3:0]            ndig,
  output logic                  busy
`ifdef MINI_BCD_SEG_EN
  ,
  output logic [7*DIGITS-1:0]   seg
`endif
);
  localparam int CW = $clog2(IN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                     state, state_nxt;
  logic [IN_W-1:0]            bin_q;
  logic [DIGITS-1:0][3:0]     scr, scr_adj, scr_nxt;
  logic [CW-1:0]              cnt;
  logic [3:0]                 ndig_nxt;
  logic                       accept, last;

  // Correct every digit in parallel before the shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    mini_bcd_add3 u_add3 (.d(scr[g]), .q(scr_adj[g]));
  end

  // Shift {scratch, bin} left by one: bin MSB enters digit 0 LSB.
  assign scr_nxt = {scr_adj[DIGITS-1:0], bin_q[IN_W-1]} >> 0;

  assign accept    = (state == IDLE) && in_valid;
  assign last      = (state == SHIFT) && (cnt == CW'(1));
  assign in_ready  = (state == IDLE);
  assign busy      = (state == SHIFT);
  assign out_valid = (state == DONE);

  // Highest nonzero digit index + 1; zero input still reports one digit.
  always_comb begin
    ndig_nxt = 4'd1;
    for (int i = 1; i < DIGITS; i++)
      if (scr_nxt[i] != 4'd0) ndig_nxt = 4'(i + 1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = SHIFT;
      SHIFT:   if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      scr   <= '0;
      cnt   <= '0;
      bcd   <= '0;
      ndig  <= 4'd1;
    end else if (accept) begin
      bin_q <= in_bin;
      scr   <= '0;
      cnt   <= CW'(IN_W);
    end else if (state == SHIFT) begin
      scr   <= scr_nxt;
      bin_q <= bin_q << 1;
      cnt   <= cnt - CW'(1);
      if (last) begin
        bcd  <= scr_nxt;
        ndig <= ndig_nxt;
      end
    end
  end

`ifdef MINI_BCD_SEG_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h3F;
      4'd1: seg7 = 7'h06;
      4'd2: seg7 = 7'h5B;
      4'd3: seg7 = 7'h4F;
      4'd4: seg7 = 7'h66;
      4'd5: seg7 = 7'h6D;
      4'd6: seg7 = 7'h7D;
      4'd7: seg7 = 7'h07;
      4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  logic [DIGITS-1:0][6:0] seg_nxt;

  always_comb begin
    seg_nxt = '0;
    for (int i = 0; i < DIGITS; i++)
      if (4'(i) < ndig_nxt) seg_nxt[i] = seg7(scr_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (rst)       seg <= {{(7*(DIGITS-1)){1'b0}}, 7'h3F};
    else if (last) seg <= seg_nxt;
  end
`endif

endmodule

// File: tb/tb_mini_bcd_conv.sv
// tb_mini_bcd_conv -- directed-vector bench for mini_bcd_conv.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_mini_bcd_conv;
  localparam int IN_W   = 17;
  localparam int DIGITS = 6;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [IN_W-1:0]     in_bin;
  logic                out_valid;
  logic                out_ready;
  logic [4*DIGITS-1:0] bcd;
  logic [3:0]          ndig;
  logic                busy;
`ifdef MINI_BCD_SEG_EN
  logic [7*DIGITS-1:0] seg;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mini_bcd_conv #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .bcd(bcd), .ndig(ndig), .busy(busy)
`ifdef MINI_BCD_SEG_EN
    , .seg(seg)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full conversion with immediate downstream accept.
  task automatic convert(input logic [IN_W-1:0] v, input logic [23:0] eb, input logic [3:0] en);
    in_valid = 1'b1;
    in_bin   = v;
    tick();                       // accept edge E0
    in_valid = 1'b0;
    chk("busy_after_accept", busy, 1'b1);
    chk("ready_low_shift", in_ready, 1'b0);
    repeat (IN_W - 1) tick();
    chk("not_done_early", out_valid, 1'b0);
    tick();                       // edge E0+IN_W
    chk("done_valid", out_valid, 1'b1);
    chk("bcd", bcd, eb);
    chk("ndig", ndig, en);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("back_idle_valid", out_valid, 1'b0);
    chk("back_idle_ready", in_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bin = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_bcd", bcd, 24'h0);
    chk("rst_ndig", ndig, 4'd1);
    chk("rst_busy", busy, 1'b0);
`ifdef MINI_BCD_SEG_EN
    chk("rst_seg", seg, {35'h0, 7'h3F});
`endif

    convert(17'd0,      24'h000000, 4'd1);
    convert(17'd131071, 24'h131071, 4'd6);
    convert(17'd1000,   24'h001000, 4'd4);
    convert(17'd99999,  24'h099999, 4'd5);
    convert(17'd8,      24'h000008, 4'd1);
`ifdef MINI_BCD_SEG_EN
    chk("seg_d0", seg[6:0], 7'h7F);
    chk("seg_hi", seg[41:7], 35'h0);
`endif

    // Back-pressure: result held, new operand ignored.
    in_valid = 1'b1; in_bin = 17'd329;
    tick();
    in_bin = 17'd77;              // in_valid stays high during SHIFT/DONE
    repeat (IN_W) tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_bcd", bcd, 24'h000329);
      chk("hold_ndig", ndig, 4'd3);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_valid", out_valid, 1'b0);
    chk("release_ready", in_ready, 1'b1);
    chk("release_keep_bcd", bcd, 24'h000329);
    chk("release_not_busy", busy, 1'b0);

    // Abort mid-conversion with reset.
    in_valid = 1'b1; in_bin = 17'd500;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ready", in_ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_valid", out_valid, 1'b0);
    chk("abort_bcd", bcd, 24'h0);
    chk("abort_ndig", ndig, 4'd1);
    convert(17'd45, 24'h000045, 4'd2);

    // Reset on the same edge as a handshake: reset wins.
    in_valid = 1'b1; in_bin = 17'd12; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_vs_accept_busy", busy, 1'b0);
    chk("rst_vs_accept_ready", in_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
